xreg2_stage: RTL and testbench
==============================

# xreg2_stage

ID→EX pipeline register (xREG2) with load-use bubble insertion, branch flush and external-stall freeze. Captures decoded control and the forwarded operands `f_reg_ra/rb/rt_data` every cycle. Drives the `xREG2_*` signals consumed by the EX stage and by the forwarding unit. Generates the PC and IF/ID write enables, and keeps a saturating count of hazard bubbles.

## Interface
Parameters:
- `CNT_W`, 16, width of the hazard bubble counter.

Ports (name, direction, width, meaning):
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  ID holds a real instruction.
- `id_do_dm_read`, `id_do_dm_write`, `id_do_reg_write`  in  1 each  decoded control.
- `id_select_write_reg`  in  2  writeback source select.
- `id_write_reg_addr`  in  5  destination register.
- `id_alu_op`  in  5  ALU operation.
- `id_imm_extend`, `id_pc`  in  32 each.
- `f_reg_ra_data`, `f_reg_rb_data`, `f_reg_rt_data`  in  32 each  forwarded operands.
- `do_hazard`  in  1  load-use hazard from the forwarding unit.
- `do_flush`  in  1  taken branch/jump resolved in EX.
- `do_ext_stall`  in  1  data memory busy; freeze the pipe.
- `xREG2_valid`, `xREG2_do_dm_read`, `xREG2_do_dm_write`, `xREG2_do_reg_write`  out  1 each.
- `xREG2_select_write_reg`  out  2.
- `xREG2_write_reg_addr`  out  5.
- `xREG2_alu_op`  out  5.
- `xREG2_imm_extend`, `xREG2_pc`, `xREG2_ra_data`, `xREG2_rb_data`, `xREG2_rt_data`  out  32 each.
- `pc_write_enable`, `ifid_write_enable`, `ifid_flush`  out  1 each  combinational.
- `stall_state`  out  2  FSM state.
- `hazard_count`  out  CNT_W  number of bubbles inserted.

## Operation
- **Priority each cycle:** ext_stall > flush > hazard > normal.
- **Normal.**
  - All xREG2 fields load from the ID inputs; `xREG2_valid` loads `id_valid`.
  - If `id_valid`=0, the stage loads a bubble instead.
  - Enables: `pc_write_enable`=1, `ifid_write_enable`=1, `ifid_flush`=0.
- **Hazard** (`do_hazard`=1, no flush, no stall).
  - xREG2 loads a bubble.
  - `pc_write_enable`=0, `ifid_write_enable`=0, so ID re-presents the same instruction next cycle.
  - `hazard_count` increments, saturating at all-ones.
- **Flush** (`do_flush`=1, no stall).
  - xREG2 loads a bubble.
  - `pc_write_enable`=1 (branch target loads), `ifid_write_enable`=1, `ifid_flush`=1.
  - A simultaneous `do_hazard` is ignored: no count, no PC hold.
- **Ext stall.**
  - All xREG2 registers hold.
  - `pc_write_enable`=0, `ifid_write_enable`=0, `ifid_flush`=0.
  - `do_flush` and `do_hazard` are ignored; the requesting stage is frozen and re-asserts them after release.
- **Bubble definition:** `valid`, `do_dm_read`, `do_dm_write`, `do_reg_write` = 0; `select_write_reg`=2'b00; `write_reg_addr`=0; `alu_op`=0; all 32-bit fields = 0.
- **FSM `stall_state`** (records the action taken last edge):
  - States: RUN=0, BUBBLE=1, FLUSH=2, HOLD=3.
  - Next state = HOLD if ext_stall, else FLUSH if flush, else BUBBLE if hazard, else RUN.
  - `stall_state` is observational only and does not gate any logic.
- **Reset** (`reset_n`=0, asynchronous): all xREG2 outputs take bubble values; `stall_state`=RUN; `hazard_count`=0.
- **Enables during reset:** combinational from the inputs; the PC/IF-ID registers are held in reset by their own logic.

## Timing
- One-cycle latency: ID values present before edge N appear on `xREG2_*` after edge N.
- `pc_write_enable`, `ifid_write_enable`, `ifid_flush` are purely combinational from `do_ext_stall`, `do_flush`, `do_hazard` in the same cycle; no registered path.
- **Load-use sequence:**
  - Cycle N: `do_hazard`=1 → bubble captured at edge N.
  - Cycle N+1: the load is in xREG3, so `do_hazard` drops and the dependent instruction is captured at edge N+1.
  - Total penalty: exactly 1 cycle.
- Back-to-back hazards each insert one bubble and each count.
- `reset_n` deassertion takes effect at the first rising edge after release; no glitch on outputs.
- `hazard_count` wraps never: it holds at 2^CNT_W−1.

## Test plan
- **Reset mid-operation:** load valid ALU instr (`write_reg_addr`=5, `ra_data`=0x1234), assert `reset_n`=0 between edges → all `xREG2_*`=0 immediately, `hazard_count`=0, `stall_state`=0.
- **Normal flow:** `id_valid`=1, `id_pc`=0x40, `f_reg_ra_data`=0xA5A5A5A5 → after one edge `xREG2_pc`=0x40, `xREG2_ra_data`=0xA5A5A5A5, enables=1/1, flush=0.
- **Load-use:** `do_hazard`=1 for one cycle → `pc_write_enable`=0 and `ifid_write_enable`=0 that cycle; next `xREG2_valid`=0; `hazard_count`=1; `stall_state`=BUBBLE; following cycle captures the held ID instruction.
- **Flush + hazard same cycle:** `do_flush`=1, `do_hazard`=1 → bubble; `pc_write_enable`=1, `ifid_flush`=1; `hazard_count` unchanged; `stall_state`=FLUSH.
- **Ext stall:** xREG2 holds `alu_op`=7; assert `do_ext_stall` 3 cycles together with `do_flush`=1 → `alu_op` stays 7, enables 0, `ifid_flush`=0, `stall_state`=HOLD; after release normal capture resumes.
- **Saturation:** with `CNT_W`=4, apply 20 hazard cycles → `hazard_count` stops at 15.

Source files
------------

// File: rtl/xreg2_stage.sv
// rtl/xreg2_stage.sv - ID to EX pipeline register with bubble, flush and external-stall control
module xreg2_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,

    input  logic             id_valid,
    input  logic             id_do_dm_read,
    input  logic             id_do_dm_write,
    input  logic             id_do_reg_write,
    input  logic [1:0]       id_select_write_reg,
    input  logic [4:0]       id_write_reg_addr,
    input  logic [4:0]       id_alu_op,
    input  logic [31:0]      id_imm_extend,
    input  logic [31:0]      id_pc,
    input  logic [31:0]      f_reg_ra_data,
    input  logic [31:0]      f_reg_rb_data,
    input  logic [31:0]      f_reg_rt_data,

    input  logic             do_hazard,
    input  logic             do_flush,
    input  logic             do_ext_stall,

    output logic             xREG2_valid,
    output logic             xREG2_do_dm_read,
    output logic             xREG2_do_dm_write,
    output logic             xREG2_do_reg_write,
    output logic [1:0]       xREG2_select_write_reg,
    output logic [4:0]       xREG2_write_reg_addr,
    output logic [4:0]       xREG2_alu_op,
    output logic [31:0]      xREG2_imm_extend,
    output logic [31:0]      xREG2_pc,
    output logic [31:0]      xREG2_ra_data,
    output logic [31:0]      xREG2_rb_data,
    output logic [31:0]      xREG2_rt_data,

    output logic             pc_write_enable,
    output logic             ifid_write_enable,
    output logic             ifid_flush,
    output logic [1:0]       stall_state,
    output logic [CNT_W-1:0] hazard_count
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_BUBBLE = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_HOLD   = 2'd3
    } stall_state_t;

    stall_state_t state_q;
    stall_state_t state_d;

    // Resolved action for this cycle: ext stall beats flush, flush beats hazard.
    logic take_stall;
    logic take_flush;
    logic take_hazard;
    logic load_bubble;

    assign take_stall  = do_ext_stall;
    assign take_flush  = !do_ext_stall && do_flush;
    assign take_hazard = !do_ext_stall && !do_flush && do_hazard;

    // An empty ID slot is captured as a bubble too, so downstream never sees stale control.
    assign load_bubble = take_flush || take_hazard || !id_valid;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Next-state and same-cycle PC / IF-ID enables from the resolved action.
    always_comb begin
        state_d           = ST_RUN;
        pc_write_enable   = 1'b1;
        ifid_write_enable = 1'b1;
        ifid_flush        = 1'b0;
        if (take_stall) begin
            state_d           = ST_HOLD;
            pc_write_enable   = 1'b0;
            ifid_write_enable = 1'b0;
        end else if (take_flush) begin
            state_d    = ST_FLUSH;
            ifid_flush = 1'b1;
        end else if (take_hazard) begin
            state_d           = ST_BUBBLE;
            pc_write_enable   = 1'b0;
            ifid_write_enable = 1'b0;
        end
    end

    // Record the action taken at each edge; purely observational.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign stall_state = state_q;

    // Pipeline register: hold on ext stall, otherwise load the ID instruction or a bubble.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            xREG2_valid            <= 1'b0;
            xREG2_do_dm_read       <= 1'b0;
            xREG2_do_dm_write      <= 1'b0;
            xREG2_do_reg_write     <= 1'b0;
            xREG2_select_write_reg <= 2'b00;
            xREG2_write_reg_addr   <= 5'd0;
            xREG2_alu_op           <= 5'd0;
            xREG2_imm_extend       <= 32'd0;
            xREG2_pc               <= 32'd0;
            xREG2_ra_data          <= 32'd0;
            xREG2_rb_data          <= 32'd0;
            xREG2_rt_data          <= 32'd0;
        end else if (!take_stall) begin
            if (load_bubble) begin
                xREG2_valid            <= 1'b0;
                xREG2_do_dm_read       <= 1'b0;
                xREG2_do_dm_write      <= 1'b0;
                xREG2_do_reg_write     <= 1'b0;
                xREG2_select_write_reg <= 2'b00;
                xREG2_write_reg_addr   <= 5'd0;
                xREG2_alu_op           <= 5'd0;
                xREG2_imm_extend       <= 32'd0;
                xREG2_pc               <= 32'd0;
                xREG2_ra_data          <= 32'd0;
                xREG2_rb_data          <= 32'd0;
                xREG2_rt_data          <= 32'd0;
            end else begin
                xREG2_valid            <= 1'b1;
                xREG2_do_dm_read       <= id_do_dm_read;
                xREG2_do_dm_write      <= id_do_dm_write;
                xREG2_do_reg_write     <= id_do_reg_write;
                xREG2_select_write_reg <= id_select_write_reg;
                xREG2_write_reg_addr   <= id_write_reg_addr;
                xREG2_alu_op           <= id_alu_op;
                xREG2_imm_extend       <= id_imm_extend;
                xREG2_pc               <= id_pc;
                xREG2_ra_data          <= f_reg_ra_data;
                xREG2_rb_data          <= f_reg_rb_data;
                xREG2_rt_data          <= f_reg_rt_data;
            end
        end
    end

    // Count inserted load-use bubbles, sticking at all-ones instead of wrapping.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hazard_count <= '0;
        end else if (take_hazard && (hazard_count != CNT_MAX)) begin
            hazard_count <= hazard_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_xreg2_stage.sv
// tb/tb_xreg2_stage.sv - self-checking bench for xreg2_stage against a behavioural model
module tb_xreg2_stage;

    localparam int CNT_W = 4;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             id_valid, id_do_dm_read, id_do_dm_write, id_do_reg_write;
    logic [1:0]       id_select_write_reg;
    logic [4:0]       id_write_reg_addr, id_alu_op;
    logic [31:0]      id_imm_extend, id_pc, f_reg_ra_data, f_reg_rb_data, f_reg_rt_data;
    logic             do_hazard, do_flush, do_ext_stall;
    logic             xREG2_valid, xREG2_do_dm_read, xREG2_do_dm_write, xREG2_do_reg_write;
    logic [1:0]       xREG2_select_write_reg;
    logic [4:0]       xREG2_write_reg_addr, xREG2_alu_op;
    logic [31:0]      xREG2_imm_extend, xREG2_pc, xREG2_ra_data, xREG2_rb_data, xREG2_rt_data;
    logic             pc_write_enable, ifid_write_enable, ifid_flush;
    logic [1:0]       stall_state;
    logic [CNT_W-1:0] hazard_count;

    xreg2_stage #(.CNT_W(CNT_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .id_valid(id_valid), .id_do_dm_read(id_do_dm_read), .id_do_dm_write(id_do_dm_write),
        .id_do_reg_write(id_do_reg_write), .id_select_write_reg(id_select_write_reg),
        .id_write_reg_addr(id_write_reg_addr), .id_alu_op(id_alu_op),
        .id_imm_extend(id_imm_extend), .id_pc(id_pc),
        .f_reg_ra_data(f_reg_ra_data), .f_reg_rb_data(f_reg_rb_data), .f_reg_rt_data(f_reg_rt_data),
        .do_hazard(do_hazard), .do_flush(do_flush), .do_ext_stall(do_ext_stall),
        .xREG2_valid(xREG2_valid), .xREG2_do_dm_read(xREG2_do_dm_read),
        .xREG2_do_dm_write(xREG2_do_dm_write), .xREG2_do_reg_write(xREG2_do_reg_write),
        .xREG2_select_write_reg(xREG2_select_write_reg), .xREG2_write_reg_addr(xREG2_write_reg_addr),
        .xREG2_alu_op(xREG2_alu_op), .xREG2_imm_extend(xREG2_imm_extend), .xREG2_pc(xREG2_pc),
        .xREG2_ra_data(xREG2_ra_data), .xREG2_rb_data(xREG2_rb_data), .xREG2_rt_data(xREG2_rt_data),
        .pc_write_enable(pc_write_enable), .ifid_write_enable(ifid_write_enable),
        .ifid_flush(ifid_flush), .stall_state(stall_state), .hazard_count(hazard_count)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the ID-to-EX slot as a list of field values; a bubble is all zeros.
    typedef logic [31:0] slot_t [12];
    slot_t m_slot;
    int    m_count;
    int    m_state;

    function automatic slot_t id_slot();
        slot_t s;
        s = '{id_valid, id_do_dm_read, id_do_dm_write, id_do_reg_write, id_select_write_reg,
              id_write_reg_addr, id_alu_op, id_imm_extend, id_pc,
              f_reg_ra_data, f_reg_rb_data, f_reg_rt_data};
        return s;
    endfunction

    function automatic slot_t dut_slot();
        slot_t s;
        s = '{xREG2_valid, xREG2_do_dm_read, xREG2_do_dm_write, xREG2_do_reg_write,
              xREG2_select_write_reg, xREG2_write_reg_addr, xREG2_alu_op, xREG2_imm_extend,
              xREG2_pc, xREG2_ra_data, xREG2_rb_data, xREG2_rt_data};
        return s;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            foreach (m_slot[i]) m_slot[i] = 32'd0;
            m_count = 0;
            m_state = 0;
        end else if (do_ext_stall) begin
            m_state = 3;
        end else if (do_flush) begin
            foreach (m_slot[i]) m_slot[i] = 32'd0;
            m_state = 2;
        end else if (do_hazard) begin
            foreach (m_slot[i]) m_slot[i] = 32'd0;
            m_count = (m_count + 1 > 15) ? 15 : m_count + 1;
            m_state = 1;
        end else begin
            if (id_valid) m_slot = id_slot();
            else foreach (m_slot[i]) m_slot[i] = 32'd0;
            m_state = 0;
        end
    end

    // Compare every output with the model away from the active edge.
    bit run_cmp = 1'b0;
    always @(negedge clock) begin
        if (run_cmp) begin
            slot_t d;
            logic pcw, ifw, ifl;
            d   = dut_slot();
            foreach (d[i]) chk($sformatf("model_field%0d", i), d[i], m_slot[i]);
            chk("model_count", 32'(hazard_count), 32'(m_count));
            chk("model_state", 32'(stall_state), 32'(m_state));
            pcw = !do_ext_stall && (do_flush || !do_hazard);
            ifl = !do_ext_stall && do_flush;
            ifw = pcw;
            chk("model_pc_we", 32'(pc_write_enable), 32'(pcw));
            chk("model_ifid_we", 32'(ifid_write_enable), 32'(ifw));
            chk("model_ifid_flush", 32'(ifid_flush), 32'(ifl));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] waddr, input logic [4:0] op,
                          input logic [31:0] pc, input logic [31:0] ra);
        id_valid            = v;
        id_do_dm_read       = 1'b0;
        id_do_dm_write      = 1'b0;
        id_do_reg_write     = v;
        id_select_write_reg = 2'b01;
        id_write_reg_addr   = waddr;
        id_alu_op           = op;
        id_imm_extend       = pc + 32'h100;
        id_pc               = pc;
        f_reg_ra_data       = ra;
        f_reg_rb_data       = ~ra;
        f_reg_rt_data       = ra ^ 32'h0F0F_0000;
    endtask

    initial begin
        reset_n = 1'b0;
        do_hazard = 1'b0; do_flush = 1'b0; do_ext_stall = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        run_cmp = 1'b1;
        #1;
        chk("reset_valid", 32'(xREG2_valid), 32'd0);
        chk("reset_count", 32'(hazard_count), 32'd0);
        chk("reset_state", 32'(stall_state), 32'd0);

        // Normal capture
        @(posedge clock); #1;
        set_id(1'b1, 5'd3, 5'd2, 32'h40, 32'hA5A5_A5A5);
        #1;
        chk("normal_pc_we", 32'(pc_write_enable), 32'd1);
        chk("normal_ifid_we", 32'(ifid_write_enable), 32'd1);
        chk("normal_ifid_flush", 32'(ifid_flush), 32'd0);
        tick();
        chk("normal_pc", xREG2_pc, 32'h40);
        chk("normal_ra", xREG2_ra_data, 32'hA5A5_A5A5);
        chk("normal_valid", 32'(xREG2_valid), 32'd1);

        // Load-use: one bubble, then the held instruction
        set_id(1'b1, 5'd4, 5'd7, 32'h44, 32'h1111_2222);
        do_hazard = 1'b1;
        #1;
        chk("hazard_pc_we", 32'(pc_write_enable), 32'd0);
        chk("hazard_ifid_we", 32'(ifid_write_enable), 32'd0);
        tick();
        chk("hazard_valid", 32'(xREG2_valid), 32'd0);
        chk("hazard_count1", 32'(hazard_count), 32'd1);
        chk("hazard_state", 32'(stall_state), 32'd1);
        do_hazard = 1'b0;
        tick();
        chk("after_hazard_pc", xREG2_pc, 32'h44);
        chk("after_hazard_alu", 32'(xREG2_alu_op), 32'd7);
        chk("after_hazard_state", 32'(stall_state), 32'd0);

        // Ext stall with flush held 3 cycles: alu_op 7 freezes
        set_id(1'b1, 5'd6, 5'd9, 32'h48, 32'h3333_4444);
        do_ext_stall = 1'b1; do_flush = 1'b1; do_hazard = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_pc_we", 32'(pc_write_enable), 32'd0);
            chk("stall_ifid_flush", 32'(ifid_flush), 32'd0);
            tick();
            chk("stall_alu", 32'(xREG2_alu_op), 32'd7);
            chk("stall_state", 32'(stall_state), 32'd3);
        end
        chk("stall_count", 32'(hazard_count), 32'd1);
        do_ext_stall = 1'b0; do_flush = 1'b0; do_hazard = 1'b0;
        tick();
        chk("release_pc", xREG2_pc, 32'h48);
        chk("release_alu", 32'(xREG2_alu_op), 32'd9);

        // Flush with simultaneous hazard
        do_flush = 1'b1; do_hazard = 1'b1;
        #1;
        chk("flush_pc_we", 32'(pc_write_enable), 32'd1);
        chk("flush_ifid_we", 32'(ifid_write_enable), 32'd1);
        chk("flush_ifid_flush", 32'(ifid_flush), 32'd1);
        tick();
        chk("flush_valid", 32'(xREG2_valid), 32'd0);
        chk("flush_pc", xREG2_pc, 32'd0);
        chk("flush_count", 32'(hazard_count), 32'd1);
        chk("flush_state", 32'(stall_state), 32'd2);
        do_flush = 1'b0; do_hazard = 1'b0;

        // Empty ID slot becomes a bubble
        set_id(1'b0, 5'd8, 5'd5, 32'h4C, 32'h5555_6666);
        tick();
        chk("idle_valid", 32'(xREG2_valid), 32'd0);
        chk("idle_addr", 32'(xREG2_write_reg_addr), 32'd0);

        // Back-to-back hazards saturate a 4-bit counter
        set_id(1'b1, 5'd2, 5'd1, 32'h50, 32'h7777_8888);
        do_hazard = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_count", 32'(hazard_count), 32'd15);
        do_hazard = 1'b0;
        tick();
        chk("sat_hold", 32'(hazard_count), 32'd15);

        // Asynchronous reset between edges
        set_id(1'b1, 5'd5, 5'd3, 32'h60, 32'h0000_1234);
        tick();
        chk("pre_reset_addr", 32'(xREG2_write_reg_addr), 32'd5);
        chk("pre_reset_ra", xREG2_ra_data, 32'h1234);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_reset_addr", 32'(xREG2_write_reg_addr), 32'd0);
        chk("mid_reset_ra", xREG2_ra_data, 32'd0);
        chk("mid_reset_valid", 32'(xREG2_valid), 32'd0);
        chk("mid_reset_count", 32'(hazard_count), 32'd0);
        chk("mid_reset_state", 32'(stall_state), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        chk("post_reset_pc", xREG2_pc, 32'h60);

        run_cmp = 1'b0;
        @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
